// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave that fronts the single-port RAM.
// The frame is a 2-bit command code followed by an 8-bit payload.
package spi_pkg;

   localparam int ADDR_W  = 8;
   localparam int FRAME_W = 10;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_e;

endpackage

// File: rtl/spi_sipo.sv
// Serial-in/parallel-out frame collector: shifts FRAME_W bits MSB first and
// flags the edge on which the last bit is taken, presenting the full word.
module spi_sipo
   import spi_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr_i,
   input  logic               en_i,
   input  logic               bit_i,
   output logic [FRAME_W-1:0] word_o,
   output logic               done_o
);

   logic [FRAME_W-1:0] shift_q;
   logic [3:0]         cnt_q;

   // word_o already includes the bit being sampled, so the parent can latch it on done_o
   assign word_o = {shift_q[FRAME_W-2:0], bit_i};
   assign done_o = en_i & ~clr_i & (cnt_q == 4'(FRAME_W - 1));

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (clr_i) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (en_i) begin
         shift_q <= word_o;
         cnt_q   <= done_o ? 4'd0 : cnt_q + 4'd1;
      end
   end

endmodule

// File: rtl/spi_slave.sv
// SPI slave bridging a serial master to the RAM rx_data/rx_valid/tx_data/tx_valid
// interface; one command bit selects write or read, then a 10-bit frame follows.
module spi_slave
   import spi_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               SS_n,
   input  logic               MOSI,
   output logic               MISO,
   output logic [FRAME_W-1:0] rx_data,
   output logic               rx_valid,
   input  logic [ADDR_W-1:0]  tx_data,
   input  logic               tx_valid
);

   state_e              state_q;
   logic                rd_addr_flag_q;
   logic                rx_got_q;
   logic                tx_loaded_q;
   logic                miso_q;
   logic                rx_valid_q;
   logic [FRAME_W-1:0]  rx_data_q;
   logic [ADDR_W-1:0]   tx_shift_q;
   logic [2:0]          tx_cnt_q;

   logic                sipo_en;
   logic                frame_done;
   logic [FRAME_W-1:0]  frame_word;

   // rx_got_q blocks further shifting once a frame is captured, until SS_n rises
   assign sipo_en = ((state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA))
                    && !rx_got_q;

   spi_sipo u_sipo (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (SS_n),
      .en_i   (sipo_en),
      .bit_i  (MOSI),
      .word_o (frame_word),
      .done_o (frame_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         rd_addr_flag_q <= 1'b0;
         rx_got_q       <= 1'b0;
         tx_loaded_q    <= 1'b0;
         miso_q         <= 1'b0;
         rx_valid_q     <= 1'b0;
         rx_data_q      <= '0;
         tx_shift_q     <= '0;
         tx_cnt_q       <= '0;
      end else begin
         rx_valid_q <= 1'b0;
         if (state_q != IDLE && SS_n) begin
            state_q     <= IDLE;
            rx_got_q    <= 1'b0;
            tx_loaded_q <= 1'b0;
            miso_q      <= 1'b0;
            tx_shift_q  <= '0;
            tx_cnt_q    <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (!SS_n) state_q <= CHK_CMD;
               end
               CHK_CMD: begin
                  if (!MOSI)               state_q <= WRITE;
                  else if (rd_addr_flag_q) state_q <= READ_DATA;
                  else                     state_q <= READ_ADD;
               end
               WRITE, READ_ADD: begin
                  if (frame_done) begin
                     rx_data_q  <= frame_word;
                     rx_valid_q <= 1'b1;
                     rx_got_q   <= 1'b1;
                     if (state_q == READ_ADD) rd_addr_flag_q <= 1'b1;
                  end
               end
               READ_DATA: begin
                  if (frame_done) begin
                     rx_data_q      <= frame_word;
                     rx_valid_q     <= 1'b1;
                     rx_got_q       <= 1'b1;
                     rd_addr_flag_q <= 1'b0;
                  end else if (rx_got_q && !tx_loaded_q) begin
                     if (tx_valid) begin
                        tx_loaded_q <= 1'b1;
                        tx_shift_q  <= tx_data;
                        miso_q      <= tx_data[ADDR_W-1];
                        tx_cnt_q    <= 3'd7;
                     end
                  end else if (tx_loaded_q) begin
                     // tx_cnt_q counts bits still to drive after the one on MISO now
                     if (tx_cnt_q != 3'd0) begin
                        miso_q     <= tx_shift_q[ADDR_W-2];
                        tx_shift_q <= tx_shift_q << 1;
                        tx_cnt_q   <= tx_cnt_q - 3'd1;
                     end else begin
                        miso_q <= 1'b0;
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign MISO     = miso_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed frames plus randomized frames
// scored against a frame-level model (last word, read-address flag, MISO byte).
module tb_spi_slave;
   import spi_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;

   int tests_run    = 0;
   int tests_failed = 0;
   int valid_cnt    = 0;
   int miso_ones    = 0;

   bit         model_flag;
   logic [9:0] model_rx;

   spi_slave dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
   );

   always #5 clk = ~clk;

   // pulse counters sampled mid-cycle; scenarios compare deltas
   always @(negedge clk) begin
      if (rx_valid === 1'b1) valid_cnt++;
      if (MISO === 1'b1) miso_ones++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic send_frame(input logic cmd, input logic [9:0] w, input int nbits,
                             input bit abort_last);
      @(negedge clk); SS_n = 1'b0; MOSI = 1'($urandom);
      @(negedge clk); MOSI = cmd;
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         MOSI = w[9-i];
         if (abort_last && i == nbits - 1) SS_n = 1'b1;
      end
   endtask

   task automatic end_frame();
      @(negedge clk); SS_n = 1'b1;
   endtask

   // mode 0: complete frame (+ RAM reply); 1: abort after k bits; 2: abort on 10th bit
   task automatic run_frame(input logic cmd, input logic [9:0] w, input int mode,
                            input int k, input logic [7:0] d);
      int         v0, m0;
      bit         is_rd_data;
      logic [7:0] got, want;
      is_rd_data = cmd && model_flag;
      v0 = valid_cnt;
      m0 = miso_ones;
      if (mode == 0) begin
         send_frame(cmd, w, 10, 1'b0);
         @(negedge clk);
         tests_run++;
         if (rx_valid !== 1'b1 || rx_data !== w) begin
            tests_failed++;
            $display("FAIL frame_word: rx_valid=%b rx_data=%h, want 1 / %h", rx_valid, rx_data, w);
         end
         model_rx = w;
         if (cmd) model_flag = !is_rd_data;
         repeat (2) begin @(negedge clk); MOSI = 1'($urandom); end
         tests_run++;
         if (MISO !== 1'b0) begin
            tests_failed++;
            $display("FAIL miso_idle: MISO=%b before RAM reply, want 0", MISO);
         end
         tx_data = d; tx_valid = 1'b1;
         @(negedge clk);
         tx_data = ~d;
         for (int i = 0; i < 8; i++) begin
            got[7-i] = MISO;
            MOSI = 1'($urandom);
            @(negedge clk);
         end
         tx_valid = 1'b0;
         want = is_rd_data ? d : 8'h00;
         tests_run++;
         if (got !== want) begin
            tests_failed++;
            $display("FAIL miso_byte: got %h want %h", got, want);
         end
         tests_run++;
         if (MISO !== 1'b0) begin
            tests_failed++;
            $display("FAIL miso_after: MISO=%b after byte, want 0", MISO);
         end
         end_frame();
         tests_run++;
         if (valid_cnt - v0 != 1) begin
            tests_failed++;
            $display("FAIL valid_count: %0d pulses, want 1", valid_cnt - v0);
         end
         if (!is_rd_data) begin
            tests_run++;
            if (miso_ones != m0) begin
               tests_failed++;
               $display("FAIL miso_quiet: %0d MISO highs, want 0", miso_ones - m0);
            end
         end
      end else begin
         send_frame(cmd, w, (mode == 1) ? k : 10, mode == 2);
         if (mode == 1) begin @(negedge clk); SS_n = 1'b1; end
         @(negedge clk);
         tests_run++;
         if (dut.state_q !== IDLE) begin
            tests_failed++;
            $display("FAIL abort_state: state=%0d want IDLE", dut.state_q);
         end
         tests_run++;
         if (valid_cnt != v0 || rx_data !== model_rx || miso_ones != m0) begin
            tests_failed++;
            $display("FAIL abort: pulses=%0d rx_data=%h miso_highs=%0d, want 0 / %h / 0",
                     valid_cnt - v0, rx_data, miso_ones - m0, model_rx);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = '0; tx_valid = 1'b0;
      model_flag = 1'b0; model_rx = '0;
      #2;
      tests_run++;
      if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 10'h000) begin
         tests_failed++;
         $display("FAIL reset_outputs: MISO=%b rx_valid=%b rx_data=%h, want 0/0/000",
                  MISO, rx_valid, rx_data);
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_write();
      run_frame(1'b0, 10'h005, 0, 0, 8'h3C);
      run_frame(1'b0, 10'h1AA, 0, 0, 8'hC3);
   endtask

   task automatic test_read();
      run_frame(1'b1, 10'h205, 0, 0, 8'h5A);
      run_frame(1'b1, 10'h300, 0, 0, 8'hA5);
   endtask

   task automatic test_abort();
      run_frame(1'b0, 10'h3FF, 1, 5, 8'h00);
      run_frame(1'b0, 10'h0F0, 2, 0, 8'h00);
      run_frame(1'b1, 10'h2FF, 1, 3, 8'h00);
   endtask

   task automatic test_async_reset();
      send_frame(1'b0, 10'h155, 10, 1'b0);
      @(negedge clk);
      tests_run++;
      if (rx_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL pre_reset_valid: rx_valid=%b want 1", rx_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if (rx_valid !== 1'b0 || rx_data !== 10'h000) begin
         tests_failed++;
         $display("FAIL reset_rx: rx_valid=%b rx_data=%h, want 0 / 000", rx_valid, rx_data);
      end
      @(negedge clk); rst_n = 1'b1; SS_n = 1'b1;
      model_flag = 1'b0; model_rx = '0;
      run_frame(1'b1, 10'h2AB, 0, 0, 8'h00);
      send_frame(1'b1, 10'h3CD, 10, 1'b0);
      @(negedge clk);
      tx_data = 8'hFF; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if (MISO !== 1'b0 || rx_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_miso: MISO=%b rx_valid=%b, want 0 / 0", MISO, rx_valid);
      end
      @(negedge clk); rst_n = 1'b1; SS_n = 1'b1;
      model_flag = 1'b0; model_rx = '0;
      run_frame(1'b1, 10'h2C3, 0, 0, 8'hE7);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++)
         run_frame(1'($urandom), 10'($urandom), 0, 0, 8'($urandom));
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++)
         run_frame(1'($urandom), 10'($urandom), int'($urandom_range(0, 2)),
                   int'($urandom_range(1, 9)), 8'($urandom));
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_abort();
      test_async_reset();
      test_back_to_back();
      test_random();
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 clk  input  1  system clock; all state advances on its rising edge; MOSI is sampled and MISO updated on this edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SS_n  input  1  chip select, active-low; high ends the frame.
REQ-004 MOSI  input  1  serial command/data from master, MSB first.
REQ-005 MISO  output  1  serial read data to master, MSB first.
REQ-006 rx_data  output  10  frame word to RAM; [9:8] = 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data; [7:0] = payload.
REQ-007 rx_valid  output  1  one-cycle strobe qualifying rx_data.
REQ-008 tx_data  input  8  read data from RAM.
REQ-009 tx_valid  input  1  qualifies tx_data.
REQ-010 One clock; reset is asynchronous and active-low.

Function
REQ-011 FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-012 IDLE -> CHK_CMD on first cycle SS_n sampled 0; else remain in IDLE.
REQ-013 CHK_CMD samples MOSI as command bit: 0 -> WRITE; 1 with rd_addr_flag=0 -> READ_ADD; 1 with rd_addr_flag=1 -> READ_DATA.
REQ-014 WRITE/READ_ADD/READ_DATA shift in exactly 10 MOSI bits, one per cycle, MSB first, via a 4-bit bit counter (0..9).
REQ-015 Cycle after the 10th bit: rx_data = shifted word, rx_valid = 1 for exactly that one cycle; rx_data holds until the next frame completes.
REQ-016 READ_ADD frame completion sets rd_addr_flag=1; READ_DATA frame completion clears it; WRITE leaves it unchanged.
REQ-017 READ_DATA, after rx_valid: wait for tx_valid=1; on that edge load tx_data into an 8-bit TX shifter and drive tx_data[7] on MISO the following cycle.
REQ-018 MISO then shifts remaining bits one per cycle (8 cycles total, bit 7 first); after bit 0, MISO = 0 and FSM waits for SS_n=1.
REQ-019 tx_valid sampled outside READ_DATA, or after the TX shifter is loaded, is ignored.
REQ-020 After 10 bits (non-READ_DATA) or after 8 MISO bits, further MOSI bits are ignored until SS_n=1.
REQ-021 SS_n=1 in any non-IDLE state: FSM -> IDLE next edge, bit counter cleared, partial word discarded, no rx_valid, MISO = 0, rd_addr_flag unchanged.
REQ-022 SS_n=1 on the same edge as the 10th bit: abort wins, no rx_valid.
REQ-023 MISO = 0 whenever not serializing read data.

Reset
REQ-024 rst_n=0 immediately forces: state=IDLE, MISO=0, rx_valid=0, rx_data=10'h000, rd_addr_flag=0, counters=0, TX shifter=0.
REQ-025 Reset mid-frame discards all partial data; first edge after release behaves as IDLE.

Structure
REQ-026 Shared package spi_pkg: state enum (3-bit), ADDR_W=8, FRAME_W=10, command codes CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
REQ-027 One sub-module spi_sipo (10-bit serial-in/parallel-out with bit counter and done pulse); MISO shifter stays inline.
REQ-028 Block is the initiator side of the RAM din/rx_valid/dout/tx_valid interface and must satisfy the RAM assertion set when connected.

Verification
REQ-029 Write: SS_n=0, MOSI 0 then 00_0000_0101 -> rx_data=10'h005, rx_valid one cycle; next frame 0 then 01_1010_1010 -> rx_data=10'h1AA.
REQ-030 Read address: 1 then 10_0000_0101 -> rx_data=10'h205, rd_addr_flag=1; MISO stays 0.
REQ-031 Read data: 1 then 11_0000_0000, RAM returns tx_data=8'hA5 with tx_valid -> MISO = 1,0,1,0,0,1,0,1 on consecutive cycles, rd_addr_flag=0.
REQ-032 Abort: SS_n=1 after 5 bits of a WRITE frame -> no rx_valid, state IDLE next cycle, rx_data unchanged.
REQ-033 Async reset asserted during MISO shift -> MISO=0 and rx_valid=0 without a clock edge; next read frame takes READ_ADD path.
REQ-034 Back-to-back frames with one-cycle SS_n high gap -> each frame produces exactly one rx_valid.
